// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_pkg
//  Brief    : Shared defaults and helper functions for the parametrised
//             single-clock FIFO and its storage array.
//  Revision : 1.0  initial release
// ============================================================================
package sync_fifo_pkg;

    localparam int c_DATA_W_DEFAULT = 64;
    localparam int c_DEPTH_DEFAULT  = 32;

    // Count must represent 0..depth inclusive, hence one bit above the address width
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // True when value is a non-zero power of two (legal DEPTH values)
    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    // True when both fill-level thresholds lie inside their legal ranges
    function automatic bit thresholds_ok(input int depth, input int af, input int ae);
        return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage : sync_fifo_pkg
`default_nettype wire

// File: rtl/fifo_sdp_ram.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sdp_ram
//  Brief    : Simple dual-port storage array: one write port and one
//             synchronous read port on the same clock. Contents not reset.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_sdp_ram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 32
) (
    input  logic                     i_clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port: store the word at the requested slot
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered output that holds between reads
    always_ff @(posedge i_clk) begin
        if (rd_en) begin
            rd_data <= r_mem[rd_addr];
        end
    end

endmodule : fifo_sdp_ram
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_param
//  Brief    : Parametrised single-clock FIFO with fill-level reporting,
//             synchronous flush and one-cycle overflow/underflow pulses.
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W    = c_DATA_W_DEFAULT,
    parameter int DEPTH     = c_DEPTH_DEFAULT,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4,
    localparam int CNT_W    = count_width(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_flush,
    input  logic              i_wren,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_rden,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_vld,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_almost_full,
    output logic              o_almost_empty,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int               c_ADDR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_AF_CNT    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] c_AE_CNT    = CNT_W'(AE_THRESH);

    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_data_vld;
    logic                r_overflow;
    logic                r_underflow;
    logic                r_data_zero;
    logic [DATA_W-1:0]   w_rd_data;

    logic w_full;
    logic w_empty;
    logic w_wr_ok;
    logic w_rd_ok;
    logic w_ovf_evt;
    logic w_unf_evt;

    // Decode acceptance and error events; reset and flush suppress everything
    always_comb begin
        w_full    = (r_count == c_DEPTH_CNT);
        w_empty   = (r_count == '0);
        w_wr_ok   = i_rstn && !i_flush && i_wren && (!w_full || i_rden);
        w_rd_ok   = i_rstn && !i_flush && i_rden && !w_empty;
        w_ovf_evt = !i_flush && i_wren && !i_rden && w_full;
        w_unf_evt = !i_flush && i_rden && w_empty;
    end

    // Pointer, count and pulse registers
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_vld  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_data_zero <= 1'b1;
        end else if (i_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_vld  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr    <= r_rd_ptr + c_ADDR_W'(1);
                r_data_zero <= 1'b0;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_data_vld  <= w_rd_ok;
            r_overflow  <= w_ovf_evt;
            r_underflow <= w_unf_evt;
        end
    end

    fifo_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .wr_en   (w_wr_ok),
        .wr_addr (r_wr_ptr),
        .wr_data (i_data),
        .rd_en   (w_rd_ok),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    // Outputs: the RAM read register is not reset, so it is masked to zero
    // until the first read after reset reloads it
    always_comb begin
        o_data         = r_data_zero ? '0 : w_rd_data;
        o_data_vld     = r_data_vld;
        o_count        = r_count;
        o_full         = (r_count == c_DEPTH_CNT);
        o_empty        = (r_count == '0);
        o_almost_full  = (r_count >= c_AF_CNT);
        o_almost_empty = (r_count <= c_AE_CNT);
        o_overflow     = r_overflow;
        o_underflow    = r_underflow;
    end

endmodule : sync_fifo_param
`default_nettype wire
